// File: rtl/serial_checking_sink_pkg.sv
// serial_checking_sink_pkg
// Shared constants, FSM state encoding and small helpers for the serial
// checking sink and its deserializer.
//
// Project-wide sizes normally come from constants.v. If the build has not
// already defined them, defaults are provided here:
//   `SIZE          node-number width (dst/src field width)
//   `NUM_NODES     number of nodes (sequence-table depth)
//   `PKT_SEQ_BITS  default sequence-field width
//   `SINK_PKT_BITS default serial payload length, 2*`SIZE + `PKT_SEQ_BITS
`ifndef SIZE
`define SIZE 4
`endif
`ifndef NUM_NODES
`define NUM_NODES 16
`endif
`ifndef PKT_SEQ_BITS
`define PKT_SEQ_BITS 8
`endif
`ifndef SINK_PKT_BITS
`define SINK_PKT_BITS (2*`SIZE+`PKT_SEQ_BITS)
`endif

package serial_checking_sink_pkg;

  localparam int NODE_BITS    = `SIZE;
  localparam int NUM_NODES    = `NUM_NODES;
  localparam int DEF_SEQ_BITS = `PKT_SEQ_BITS;

  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CHECK = 2'd2,
    ST_HOLD  = 2'd3
  } sink_state_e;

  // Payload length on the wire: dst, src, then seq, no start/stop bits.
  function automatic int pkt_bits(input int seq_bits);
    return (32'sd2 * NODE_BITS) + seq_bits;
  endfunction

  // Width of a down-counter able to hold the value 'hold' (at least 1 bit).
  function automatic int hold_width(input int hold);
    if (hold < 32'sd2) begin
      return 32'sd1;
    end else begin
      return $clog2(hold + 32'sd1);
    end
  endfunction

  // 16-bit increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    if (value == COUNT_MAX) begin
      return value;
    end else begin
      return value + 16'd1;
    end
  endfunction

endpackage

// File: rtl/serial_checking_sink_if.sv
// serial_checking_sink_if
// One-bit serial link between a router local output and a sink.
//   rx_data  serial data, idle low; a 1 in idle is a start bit
//   rx_busy  backpressure; a transmitter only starts while it is low
// Modports:
//   master  transmitter side (drives rx_data, observes rx_busy)
//   slave   sink side (observes rx_data, drives rx_busy)
interface serial_checking_sink_if;

  logic rx_data;
  logic rx_busy;

  modport master (output rx_data, input rx_busy);
  modport slave  (input rx_data, output rx_busy);

endinterface

// File: rtl/serial_checking_sink_deshift.sv
// serial_deshift
// Bit counter plus shift register for one LSB-first serial payload.
// While shift_en is high one bit is taken per cycle; on the cycle that
// carries the last bit, done is high and word_next presents the complete
// payload (the stored bits plus the bit currently on bit_in), so the
// caller can register the finished word on that same edge.
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous, active-low clear
//   start      clears the bit counter (start bit seen)
//   shift_en   take bit_in this cycle
//   bit_in     serial data bit
//   word_next  assembled payload including bit_in, bit 0 = first bit
//   done       last payload bit is being taken this cycle
module serial_deshift #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] word_next,
  output logic             done
);

  localparam int CNT_W = (WIDTH < 2) ? 1 : $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  // Only WIDTH-1 bits are stored; the final bit is still on bit_in at done.
  logic [WIDTH-2:0] shift_r;
  logic [CNT_W-1:0] cnt_r;

  assign word_next = {bit_in, shift_r};
  assign done      = shift_en && (cnt_r == LAST_BIT);

  // Bit counter: restarts on every start bit, advances per shifted bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (start) begin
      cnt_r <= '0;
    end else if (shift_en) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Shift register: new bits enter at the top so the first bit ends at 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_r <= '0;
    end else if (shift_en) begin
      shift_r <= word_next[WIDTH-1:1];
    end else begin
      shift_r <= shift_r;
    end
  end

endmodule

// File: rtl/serial_checking_sink.sv
// serial_checking_sink
// Terminating endpoint for one router local serial output. Receives a start
// bit followed by dst, src, seq (LSB first), checks the destination against
// ID and, optionally, the per-source sequence number, reports each packet
// with a one-cycle pkt_valid pulse and keeps saturating packet/error
// counters. After each packet it holds rx_busy for HOLD_CYCLES extra
// cycles to model a slow consumer.
//
// Optional feature macro:
//   SINK_SEQ_CHECK_EN  keep a table of expected sequence numbers per source
//                      and flag out-of-order packets. Undefined: dst only.
//
// Parameters: ID (own node number), SEQ_BITS (seq field width),
//             HOLD_CYCLES (busy cycles after each packet, 0 allowed).
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous, active-low; clears all state
//   link       serial link, slave side (rx_data in, rx_busy out)
//   pkt_valid  one-cycle pulse, packet fields valid
//   pkt_src    source field of last packet
//   pkt_seq    sequence field of last packet
//   pkt_err    high with pkt_valid when the packet failed a check
//   pkt_count  packets received, saturating
//   err_count  failed packets, saturating
//   active     high whenever the sink is not idle
module serial_checking_sink
  import serial_checking_sink_pkg::*;
#(
  parameter int ID          = 0,
  parameter int SEQ_BITS    = DEF_SEQ_BITS,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  serial_checking_sink_if.slave link,
  output logic                  pkt_valid,
  output logic [NODE_BITS-1:0]  pkt_src,
  output logic [SEQ_BITS-1:0]   pkt_seq,
  output logic                  pkt_err,
  output logic [15:0]           pkt_count,
  output logic [15:0]           err_count,
  output logic                  active
);

  localparam int PKT_BITS = pkt_bits(SEQ_BITS);
  localparam int HOLD_W   = hold_width(HOLD_CYCLES);
  localparam bit HOLD_EN  = (HOLD_CYCLES > 0);
  localparam logic [NODE_BITS-1:0] OWN_ID    = NODE_BITS'(ID);
  localparam logic [HOLD_W-1:0]    HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

  sink_state_e state_r;
  sink_state_e state_nxt_s;

  logic                 busy_r;
  logic [HOLD_W-1:0]    hold_cnt_r;
  logic                 start_s;
  logic                 shift_en_s;
  logic                 done_s;
  logic [PKT_BITS-1:0]  word_s;
  logic [NODE_BITS-1:0] dst_s;
  logic [NODE_BITS-1:0] src_s;
  logic [SEQ_BITS-1:0]  seq_s;
  logic                 dst_err_s;
  logic                 seq_err_s;

  logic                 pkt_valid_r;
  logic                 pkt_err_r;
  logic [NODE_BITS-1:0] pkt_src_r;
  logic [SEQ_BITS-1:0]  pkt_seq_r;
  logic [15:0]          pkt_count_r;
  logic [15:0]          err_count_r;

  assign start_s    = (state_r == ST_IDLE) && link.rx_data;
  assign shift_en_s = (state_r == ST_RECV);

  serial_deshift #(
    .WIDTH (PKT_BITS)
  ) u_deshift (
    .clk       (clk),
    .reset     (reset),
    .start     (start_s),
    .shift_en  (shift_en_s),
    .bit_in    (link.rx_data),
    .word_next (word_s),
    .done      (done_s)
  );

  // Field split of the word completing this cycle (valid while done_s).
  assign dst_s     = word_s[NODE_BITS-1:0];
  assign src_s     = word_s[2*NODE_BITS-1:NODE_BITS];
  assign seq_s     = word_s[PKT_BITS-1:2*NODE_BITS];
  assign dst_err_s = (dst_s != OWN_ID);

`ifdef SINK_SEQ_CHECK_EN
  logic [SEQ_BITS-1:0] seq_exp_r [NUM_NODES];

  assign seq_err_s = (seq_exp_r[src_s] != seq_s);

  // Expected-sequence table: always resynchronises to seq+1, error or not.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_NODES; i++) begin
        seq_exp_r[i] <= '0;
      end
    end else if (done_s) begin
      seq_exp_r[src_s] <= seq_s + SEQ_BITS'(1);
    end else begin
      seq_exp_r <= seq_exp_r;
    end
  end
`else
  assign seq_err_s = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (link.rx_data) begin
          state_nxt_s = ST_RECV;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (done_s) begin
          state_nxt_s = ST_CHECK;
        end else begin
          state_nxt_s = ST_RECV;
        end
      end
      ST_CHECK: begin
        if (HOLD_EN) begin
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HOLD: begin
        // Counter is loaded with HOLD_CYCLES, so the visit ending at 1
        // is the last of exactly HOLD_CYCLES hold cycles.
        if (hold_cnt_r <= HOLD_W'(1)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Busy flag registered from the next state, so it equals (state != IDLE).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != ST_IDLE);
    end
  end

  // Post-packet hold counter: loaded in CHECK, counts down in HOLD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt_r <= '0;
    end else if (state_r == ST_CHECK) begin
      hold_cnt_r <= HOLD_LOAD;
    end else if ((state_r == ST_HOLD) && (hold_cnt_r != '0)) begin
      hold_cnt_r <= hold_cnt_r - HOLD_W'(1);
    end else begin
      hold_cnt_r <= hold_cnt_r;
    end
  end

  // Packet report: registered on the last data bit so it shows in CHECK.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_valid_r <= 1'b0;
      pkt_err_r   <= 1'b0;
      pkt_src_r   <= '0;
      pkt_seq_r   <= '0;
    end else if (done_s) begin
      pkt_valid_r <= 1'b1;
      pkt_err_r   <= dst_err_s | seq_err_s;
      pkt_src_r   <= src_s;
      pkt_seq_r   <= seq_s;
    end else begin
      pkt_valid_r <= 1'b0;
      pkt_err_r   <= 1'b0;
      pkt_src_r   <= pkt_src_r;
      pkt_seq_r   <= pkt_seq_r;
    end
  end

  // Saturating counters, bumped at the end of CHECK.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_count_r <= 16'h0000;
      err_count_r <= 16'h0000;
    end else if (state_r == ST_CHECK) begin
      pkt_count_r <= sat_inc16(pkt_count_r);
      if (pkt_err_r) begin
        err_count_r <= sat_inc16(err_count_r);
      end else begin
        err_count_r <= err_count_r;
      end
    end else begin
      pkt_count_r <= pkt_count_r;
      err_count_r <= err_count_r;
    end
  end

  assign link.rx_busy = busy_r;
  assign active       = busy_r;
  assign pkt_valid    = pkt_valid_r;
  assign pkt_err      = pkt_err_r;
  assign pkt_src      = pkt_src_r;
  assign pkt_seq      = pkt_seq_r;
  assign pkt_count    = pkt_count_r;
  assign err_count    = err_count_r;

endmodule

// File: doc/serial_checking_sink.md
# serial_checking_sink

- Terminating endpoint for one router local (port 4) serial output.
- Accepts serial packets on the 1-bit data/busy link and deserializes them.
- Checks destination, and optionally per-source sequence numbers, and keeps packet and error counters.
- Applies configurable post-packet backpressure so benches and the FPGA top can model slow consumers.

## Interface
Parameters:
- ID, 0, node number of this sink; expected destination field.
- SEQ_BITS, 8, width of packet sequence field.
- HOLD_CYCLES, 4, busy cycles inserted after each packet (0 allowed).

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- rx_data  input  1  serial line from router tx_data[ID][4]; idle 0.
- rx_busy  output  1  backpressure to router tx_busy[ID][4].
- pkt_valid  output  1  one-cycle pulse, packet fields valid.
- pkt_src  output  `SIZE  source field of last packet.
- pkt_seq  output  SEQ_BITS  sequence field of last packet.
- pkt_err  output  1  qualifies pkt_valid; packet failed a check.
- pkt_count  output  16  packets received, saturating.
- err_count  output  16  failed packets, saturating.
- active  output  1  high whenever not IDLE (LED hook).

## Operation
- Link protocol:
  - Idle line is 0.
  - A packet is a start bit of 1, then PKT_BITS = 2*`SIZE+SEQ_BITS data bits, LSB first, one bit per cycle, no stop bit.
  - Packet layout, LSB up: dst[`SIZE], src[`SIZE], seq[SEQ_BITS].
  - A transmitter starts only while rx_busy is 0.
- FSM states: IDLE, RECV, CHECK, HOLD. Reset state is IDLE.
  - IDLE: rx_data==1 sampled, go to RECV with bit counter 0. 0 stays in IDLE.
  - RECV: shift one bit per cycle. After bit PKT_BITS-1, go to CHECK.
  - CHECK: exactly one cycle, then HOLD loaded with HOLD_CYCLES, or IDLE if HOLD_CYCLES==0.
  - HOLD: decrement the counter; at 0, go to IDLE.
- rx_busy = active = (state != IDLE), decoded from registered state.
- CHECK actions:
  - pkt_valid = 1; pkt_src and pkt_seq are already registered.
  - Error if dst != ID, and also on sequence mismatch when enabled; pkt_err reflects this.
  - pkt_count increments. err_count increments on error. Both saturate at 16'hFFFF.
- rx_data during RECV is always data, even when 1. rx_data during CHECK or HOLD is ignored (protocol violation, no error).
- Reset values:
  - All outputs 0.
  - pkt_src and pkt_seq are 0.
  - Sequence table all 0.

## Timing
- Start bit sampled at cycle 0:
  - data bits sampled cycles 1..PKT_BITS;
  - CHECK, and pkt_valid, in cycle PKT_BITS+1;
  - HOLD occupies the next HOLD_CYCLES cycles;
  - IDLE follows.
- rx_busy rises the cycle after the start bit and falls on entry to IDLE.
- The earliest next start bit is sampled in the first IDLE cycle.
- Counters show their new values the cycle after CHECK.
- Reset asserted mid-packet: the partial packet is discarded, no counter change, and the FSM is in IDLE with rx_busy=0 while reset is low.

## Configuration
- SINK_SEQ_CHECK_EN defined:
  - Holds a `NUM_NODES-entry table of expected sequence numbers, indexed by src.
  - On mismatch with exp[src], the packet is flagged as an error.
  - In all cases, exp[src] <= seq+1 mod 2^SEQ_BITS (resynchronise).
- Undefined: no table; only the dst check applies.

## Structure
- `SIZE, `NUM_NODES stay in constants.v.
- Add `PKT_SEQ_BITS (default for SEQ_BITS) and `SINK_PKT_BITS to constants.v.
- One sub-module: serial_deshift (bit counter and PKT_BITS shift register, with a done strobe). The FSM, checks and counters stay in the top.

## Test plan
- ID=15, SIZE=4, SEQ_BITS=8: send 16'h000F (dst 15, src 0, seq 0) starting cycle 0 -> pkt_valid in cycle 17, pkt_err=0, pkt_count=1; rx_busy high cycles 1..21, low from 22.
- Send 16'h000E (dst 14) -> pkt_err=1, err_count=1, pkt_count=1.
- Back-to-back packets from src 3 with seq 0,1,2 (each start bit in the first IDLE cycle) -> pkt_count=3, err_count=0.
- SINK_SEQ_CHECK_EN: src 3 seq 0, then seq 2 -> the second packet is an error, err_count=1. A following seq 3 is then error-free.
- Reset low at data bit 5 -> rx_busy=0, counters unchanged; the next full packet is received correctly.
- Force pkt_count to 16'hFFFF via 65535 packets (or an accelerated bench) -> stays 16'hFFFF on the next packet.
